// File: rtl/pslip_pkg.sv
// Shared width helpers for the pSLIP priority/round-robin selector blocks.
package pslip_pkg;

    // Priority field width for P levels (level 0 means "no request").
    function automatic int unsigned pri_w(input int unsigned p);
        return (p < 2) ? 1 : $clog2(p);
    endfunction

    // Port index width for N ports, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set bit of match at or after ptr, wrapping modulo N.
module rr_pick
    import pslip_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0]        match,
    input  logic [idx_w(N)-1:0] ptr,
    output logic [N-1:0]        onehot,
    output logic [idx_w(N)-1:0] idx,
    output logic                any
);

    localparam int unsigned IW = idx_w(N);

    logic [N-1:0] rot_c;
    logic [IW-1:0] off_c;
    logic [IW:0]   sum_c;

    // Rotate the doubled request vector so ptr lands at bit 0, then priority-encode.
    always_comb begin
        rot_c  = N'({match, match} >> ptr);
        off_c  = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot_c[j]) off_c = IW'(j);
        end
        // Map the rotated offset back to a port index with an explicit wrap at N.
        sum_c = {1'b0, ptr} + {1'b0, off_c};
        if (sum_c >= (IW+1)'(N)) sum_c = sum_c - (IW+1)'(N);
        any    = |match;
        idx    = any ? sum_c[IW-1:0] : '0;
        onehot = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/pri_rr_sel_pipe.sv
// Two-stage max-priority selector with round-robin tie break and valid/ready flow.
module pri_rr_sel_pipe
    import pslip_pkg::*;
#(
    parameter int unsigned N        = 32,
    parameter int unsigned P        = 16,
    parameter int unsigned PTR_INIT = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [pri_w(P)-1:0] pri_in [0:N-1],
    output logic                out_valid,
    input  logic                out_ready,
    output logic                gnt_any,
    output logic [N-1:0]        gnt_onehot,
    output logic [idx_w(N)-1:0] gnt_idx,
    output logic [pri_w(P)-1:0] max_pri,
    output logic [idx_w(N)-1:0] rr_ptr
);

    localparam int unsigned PW = pri_w(P);
    localparam int unsigned IW = idx_w(N);

    typedef logic [PW-1:0] pri_t;

    pri_t          max_c;
    logic [N-1:0]  match_c;
    logic          s1_valid;
    pri_t          s1_max;
    logic [N-1:0]  s1_match;
    logic          s2_ld_c;
    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_nxt_c;
    logic [N-1:0]  pick_onehot_c;
    logic [IW-1:0] pick_idx_c;
    logic          pick_any_c;

    // Maximum priority over all ports and the set of ports that hold it.
    always_comb begin
        max_c = '0;
        for (int i = 0; i < N; i++) begin
            if (pri_in[i] > max_c) max_c = pri_in[i];
        end
        match_c = '0;
        for (int i = 0; i < N; i++) begin
            match_c[i] = (max_c != '0) && (pri_in[i] == max_c);
        end
    end

    assign s2_ld_c  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_ld_c;
    assign rr_ptr   = ptr;

    // Pointer value after this edge; a stage-2 load sees an accept happening now.
    always_comb begin
        ptr_nxt_c = ptr;
        if (out_valid && out_ready && gnt_any) begin
            ptr_nxt_c = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
        end
    end

    rr_pick #(.N(N)) u_pick (
        .match  (s1_match),
        .ptr    (ptr_nxt_c),
        .onehot (pick_onehot_c),
        .idx    (pick_idx_c),
        .any    (pick_any_c)
    );

    // Stage 1: capture max and match vector on input handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_max   <= '0;
            s1_match <= '0;
        end else if (in_valid && in_ready) begin
            s1_valid <= 1'b1;
            s1_max   <= max_c;
            s1_match <= match_c;
        end else if (s2_ld_c) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: register the round-robin winner; hold while backpressured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            gnt_any    <= 1'b0;
            gnt_onehot <= '0;
            gnt_idx    <= '0;
            max_pri    <= '0;
        end else if (s2_ld_c) begin
            out_valid  <= 1'b1;
            gnt_any    <= pick_any_c;
            gnt_onehot <= pick_onehot_c;
            gnt_idx    <= pick_idx_c;
            max_pri    <= s1_max;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // Round-robin pointer advances only past an accepted, non-empty grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= IW'(PTR_INIT);
        end else begin
            ptr <= ptr_nxt_c;
        end
    end

endmodule

// File: doc/pri_rr_sel_pipe.md
Name: pri_rr_sel_pipe

Overview:
- Parametrised, pipelined successor to the combinational priority selector in the pSLIP scheduler.
- Takes N per-port request priorities, finds the maximum non-zero priority, and breaks ties among equal-max requesters with an iSLIP-style round-robin pointer.
- Emits one-hot grant, grant index and winning priority through a 2-stage valid/ready pipeline.
- Sits between the per-input VOQ priority encoders and the output-port accept logic.

Parameters:
- N, 32, number of requesting ports; any value >= 2, not restricted to a power of 2.
- P, 16, number of priority levels; priority width PW = $clog2(P); level 0 means "no request".
- PTR_INIT, 0, reset value of the round-robin pointer, range 0..N-1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  priority vector present.
- in_ready  output  1  block can accept the vector this cycle.
- pri_in  input  [PW-1:0] x N (unpacked array 0..N-1)  per-port priority.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result; this is the iSLIP accept.
- gnt_any  output  1  at least one port had non-zero priority.
- gnt_onehot  output  N  granted port, one-hot or all zero.
- gnt_idx  output  $clog2(N)  granted port index; 0 when gnt_any=0.
- max_pri  output  PW  winning priority; 0 when none.
- rr_ptr  output  $clog2(N)  current pointer, for debug.

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - Both stage valid bits are 0, so out_valid=0.
  - gnt_any=0, gnt_onehot=0, gnt_idx=0, max_pri=0, rr_ptr=PTR_INIT.
  - in_ready=1 on the first cycle after deassertion.
  - Reset mid-operation discards all in-flight vectors; there is no partial output.
- Stage 1 register (s1):
  - Loads when in_valid && in_ready.
  - Captures max = maximum over pri_in, computed with an unsigned compare.
  - Captures match[i] = (max != 0) && (pri_in[i] == max).
- Stage 2 register (output):
  - Loads from s1 when s1_valid && (!out_valid || out_ready).
  - Winner = first i with match[i]=1, scanning i = ptr_nxt, ptr_nxt+1, ... with wrap modulo N.
  - Registers gnt_onehot, gnt_idx, max_pri, and gnt_any = |match.
- Ready chain:
  - s2_ld = s1_valid && (!out_valid || out_ready).
  - in_ready = !s1_valid || s2_ld.
  - Full throughput is one vector per cycle. Latency is exactly 2 cycles from input handshake to out_valid when not backpressured.
- Backpressure:
  - While out_valid && !out_ready, all outputs are held stable.
  - s1 holds its data, and in_ready=0 once s1 is occupied.
  - No vector is dropped or duplicated.
- Pointer update:
  - On out_valid && out_ready && gnt_any: ptr <= (gnt_idx == N-1) ? 0 : gnt_idx+1.
  - Otherwise ptr holds. An unaccepted grant or an all-zero result never moves the pointer.
- Pointer bypass:
  - ptr_nxt is the value ptr takes at the next edge.
  - A stage-2 load in the same cycle as an accepting handshake uses the updated pointer. Back-to-back results are therefore fair.
- Boundary cases:
  - Single match: granted regardless of the pointer.
  - All N ports tied: grants go to ptr, ptr+1, ... in order.
  - ptr = N-1 wraps to 0.
  - Non-power-of-2 N: indices >= N are never produced.
- Arithmetic: all compares are unsigned; the pointer increment wraps explicitly at N, never relying on natural overflow.

Decomposition:
- Package pslip_pkg holds:
  - Function pri_w(P) returning $clog2(P).
  - Function idx_w(N) returning max(1, $clog2(N)).
  - Typedef of a packed priority type parametrised via localparams at the use site.
- Sub-module rr_pick:
  - Parameter N; inputs match[N-1:0] and ptr; outputs onehot, idx, any.
  - Purely combinational double-width rotate-and-priority-encode.
  - Reused by the accept arbiter.
- The max-reduction stays inline as a loop; no separate tree module.

Test Plan (all with N=32, P=16):
- Reset/idle: deassert rst_n with no input -> out_valid=0, rr_ptr=0 and in_ready=1 on the cycle after deassertion; outputs all zero.
- Simple max: pri_in[5]=9, pri_in[20]=3, others 0, out_ready=1 -> 2 cycles later gnt_idx=5, gnt_onehot=32'h20, max_pri=9, gnt_any=1; rr_ptr becomes 6.
- Round-robin ties: ports 3, 10, 31 all =15, vector held valid 4 cycles, out_ready=1 -> gnt_idx sequence 3, 10, 31, 3; rr_ptr goes 4, 11, 0, 4.
- No request: all pri_in=0 -> out_valid=1, gnt_any=0, gnt_onehot=0, max_pri=0; rr_ptr unchanged.
- Backpressure: out_ready=0 for 5 cycles while 3 vectors are offered:
  - Outputs stay stable.
  - in_ready drops after 2 accepted vectors.
  - On release, the 3 results emerge in order and none are lost.
  - rr_ptr moves only on accepted grants.
- Reset mid-flight: assert rst_n=0 with both stages full -> out_valid=0 asynchronously; after release, no stale result appears and rr_ptr=0.
